// File: rtl/pll_phase_ctrl.sv
// SDRAM clocking PLL supervisor: reset pulse, filtered lock, ready release,
// and a dynamic phase-step sequencer driving PSSEL/PSDIR/PSPULSE.
//
// state        | meaning
// RST_PLL      | pll_reset held high for RST_CYCLES
// WAIT_LOCK    | filtering lock_s, bounded by LOCK_TIMEOUT
// READY        | locked and idle, accepting phase-step requests
// PS_HIGH      | pll_pspulse high for PULSE_CYCLES
// PS_LOW       | pll_pspulse low gap for PULSE_CYCLES
// PS_SETTLE    | waiting for the shifted clock to settle before ack
module pll_phase_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_FILTER  = 8,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int PULSE_CYCLES = 4,
    parameter int PS_SETTLE    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [2:0] pll_pssel,
    output logic       pll_psdir,
    output logic       pll_pspulse,
    output logic       ready,
    input  logic       ps_req,
    input  logic [2:0] ps_sel,
    input  logic       ps_dir,
    input  logic [3:0] ps_steps,
    output logic       ps_busy,
    output logic       ps_ack,
    output logic       ps_err,
    output logic [7:0] relock_count,
    output logic       timeout_err
);

    localparam int CW = 16;
    localparam int FW = $clog2(LOCK_FILTER + 1);

    typedef enum logic [2:0] {
        ST_RST_PLL, ST_WAIT_LOCK, ST_READY, ST_PS_HIGH, ST_PS_LOW, ST_PS_SETTLE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] filt_q, filt_d;
    logic [3:0]    steps_q, steps_d;
    logic          lock_meta, lock_s;
    logic          in_ps_q, in_ps_d, lock_lost;
    logic          pll_reset_d, ready_d, pspulse_d, busy_d, ack_d, err_d, tmo_d, psdir_d;
    logic [2:0]    pssel_d;
    logic [7:0]    relock_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    assign in_ps_q   = (state_q == ST_PS_HIGH) || (state_q == ST_PS_LOW) || (state_q == ST_PS_SETTLE);
    assign in_ps_d   = (state_d == ST_PS_HIGH) || (state_d == ST_PS_LOW) || (state_d == ST_PS_SETTLE);
    assign lock_lost = (in_ps_q || (state_q == ST_READY)) && !lock_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RST_PLL;
            cnt_q        <= '0;
            filt_q       <= '0;
            steps_q      <= '0;
            pll_reset    <= 1'b1;
            ready        <= 1'b0;
            pll_pssel    <= 3'd0;
            pll_psdir    <= 1'b0;
            pll_pspulse  <= 1'b0;
            ps_busy      <= 1'b0;
            ps_ack       <= 1'b0;
            ps_err       <= 1'b0;
            relock_count <= 8'd0;
            timeout_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            filt_q       <= filt_d;
            steps_q      <= steps_d;
            pll_reset    <= pll_reset_d;
            ready        <= ready_d;
            pll_pssel    <= pssel_d;
            pll_psdir    <= psdir_d;
            pll_pspulse  <= pspulse_d;
            ps_busy      <= busy_d;
            ps_ack       <= ack_d;
            ps_err       <= err_d;
            relock_count <= relock_d;
            timeout_err  <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        filt_d  = filt_q;
        steps_d = steps_q;
        if (lock_lost) begin
            state_d = ST_RST_PLL;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_RST_PLL: begin
                    if (cnt_q == CW'(RST_CYCLES - 1)) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                        filt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (filt_q == FW'(LOCK_FILTER)) begin
                        state_d = ST_READY;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                        state_d = ST_RST_PLL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d  = cnt_q + CW'(1);
                        filt_d = lock_s ? filt_q + FW'(1) : '0;
                    end
                end
                ST_READY: begin
                    // ps_ack high means the requester has not yet seen completion and may still hold ps_req
                    if (ps_req && !ps_ack) begin
                        steps_d = ps_steps;
                        if (ps_steps == 4'd0) begin
                            state_d = ST_PS_SETTLE;
                            cnt_d   = CW'(PS_SETTLE - 1);
                        end else begin
                            state_d = ST_PS_HIGH;
                            cnt_d   = '0;
                        end
                    end
                end
                ST_PS_HIGH: begin
                    if (cnt_q == CW'(PULSE_CYCLES - 1)) begin
                        state_d = ST_PS_LOW;
                        cnt_d   = '0;
                        steps_d = steps_q - 4'd1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_PS_LOW: begin
                    if (cnt_q == CW'(PULSE_CYCLES - 1)) begin
                        state_d = (steps_q != 4'd0) ? ST_PS_HIGH : ST_PS_SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_PS_SETTLE: begin
                    if (cnt_q == CW'(PS_SETTLE - 1)) begin
                        state_d = ST_READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_RST_PLL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pll_reset_d = (state_d == ST_RST_PLL);
        ready_d     = (state_d == ST_READY) || in_ps_d;
        pspulse_d   = (state_d == ST_PS_HIGH);
        err_d       = lock_lost && in_ps_q;
        ack_d       = err_d || ((state_q == ST_PS_SETTLE) && (state_d == ST_READY));
        busy_d      = in_ps_d || (ack_d && !err_d);
        pssel_d     = pll_pssel;
        psdir_d     = pll_psdir;
        if ((state_q == ST_READY) && in_ps_d) begin
            pssel_d = ps_sel;
            psdir_d = ps_dir;
        end
        relock_d = relock_count;
        if (lock_lost && (relock_count != 8'hFF))
            relock_d = relock_count + 8'd1;
        tmo_d = timeout_err || ((state_q == ST_WAIT_LOCK) && (state_d == ST_RST_PLL));
    end

endmodule

// File: doc/pll_phase_ctrl.md
Name: pll_phase_ctrl

Overview:
Supervisor and sequencer for the SDRAM clocking PLL. It pulses the PLL reset, waits for a filtered lock, and then releases `ready` to the SDRAM controller. On loss of lock it re-runs the sequence. It also owns the PLL dynamic phase-shift pins (PSSEL/PSDIR/PSPULSE) and serves step requests, so that read-capture calibration can slide the `clkout2` phase.

Parameters:
- RST_CYCLES, 16: cycles `pll_reset` is held high per reset attempt (>=1).
- LOCK_FILTER, 8: consecutive synchronized lock-high cycles required before ready (>=1).
- LOCK_TIMEOUT, 65535: cycles in WAIT_LOCK before a retry (>=LOCK_FILTER).
- PULSE_CYCLES, 4: `pll_pspulse` high width, and also the low gap between pulses (>=2).
- PS_SETTLE, 16: cycles after the last pulse before acknowledging (>=1).

Ports:
- clk  in  1  free-running 50 MHz board clock (never a PLL output)
- rst  in  1  reset
- pll_lock  in  1  PLL LOCK, asynchronous; 2-FF synchronized internally
- pll_reset  out  1  to PLL RESET
- pll_pssel  out  3  to PLL PSSEL, output channel select
- pll_psdir  out  1  to PLL PSDIR
- pll_pspulse  out  1  to PLL PSPULSE
- ready  out  1  PLL locked and stable; downstream reset release
- ps_req  in  1  phase-step request, level, held until ps_ack
- ps_sel  in  3  channel for request
- ps_dir  in  1  direction for request
- ps_steps  in  4  number of steps, 0..15
- ps_busy  out  1  request in progress
- ps_ack  out  1  one-cycle completion pulse
- ps_err  out  1  valid with ps_ack; 1 = aborted by lock loss
- relock_count  out  8  lock-loss events, saturates at 255
- timeout_err  out  1  sticky; a lock timeout occurred

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (`clk`, `rst`). All outputs are registered.
- Reset values:
  - pll_reset=1
  - ready=0
  - pll_pssel=0, pll_psdir=0, pll_pspulse=0
  - ps_busy=0, ps_ack=0, ps_err=0
  - relock_count=0, timeout_err=0
  - FSM=RST_PLL, counters=0
- Lock synchronizer: lock_s is the output of the 2-FF synchronizer, so it lags pll_lock by 2 cycles. All decisions use lock_s.
- FSM states: RST_PLL, WAIT_LOCK, READY, PS_HIGH, PS_LOW, PS_SETTLE.
- RST_PLL:
  - pll_reset=1 for exactly RST_CYCLES cycles, counted from rst deassertion or from state entry.
  - Then go to WAIT_LOCK with pll_reset=0.
- WAIT_LOCK:
  - A filter counter increments while lock_s=1 and clears on lock_s=0.
  - When the filter count reaches LOCK_FILTER, go to READY; ready=1 on the entry cycle.
  - A timeout counter counts every cycle in this state. When it reaches LOCK_TIMEOUT first: timeout_err<=1, go to RST_PLL.
- READY (idle):
  - If ps_req=1, capture ps_sel/ps_dir/ps_steps onto pll_pssel/pll_psdir and an internal step count; ps_busy<=1.
  - If steps=0, go to PS_SETTLE directly. Otherwise go to PS_HIGH.
  - ps_req is ignored in every other state; it is not latched.
- PS_HIGH: pll_pspulse=1 for PULSE_CYCLES cycles. Decrement the step count on exit. Go to PS_LOW.
- PS_LOW: pll_pspulse=0 for PULSE_CYCLES cycles. Then go to PS_HIGH if steps remain, else PS_SETTLE.
- PS_SETTLE:
  - Wait PS_SETTLE cycles; for steps=0 the wait is 1 cycle.
  - Then ps_ack=1, ps_err=0, ps_busy<=0, return to READY.
  - The ack cycle is the last cycle with ps_busy=1.
  - pll_pssel/pll_psdir hold their values after ack until the next capture.
- ready stays 1 throughout PS_* states.
- Lock loss: lock_s=0 in READY or any PS_* state triggers, on the next edge:
  - ready=0, pll_pspulse=0, relock_count+1 (saturating).
  - If ps_busy: ps_ack=1, ps_err=1, ps_busy=0.
  - Go to RST_PLL.
- Simultaneous events: lock loss in the same cycle as ps_req in READY means lock loss wins; the request is not accepted and no ack is issued.
- Reset mid-operation: asynchronous return to reset values. pll_pspulse drops immediately; no ack is issued.
- Pulse count: exactly ps_steps rising edges of pll_pspulse per accepted request.

Test Plan:
- Power-up (defaults): pll_lock tied 1 from t=0, rst released at cycle 0.
  - pll_reset high for cycles 0..15.
  - ready rises at cycle 16+2+8 ±1 per implementation.
  - Check the exact value against the RTL.
- Request sel=2, dir=1, steps=3 in READY:
  - Exactly 3 pspulse pulses, each 4 high / 4 low.
  - pssel=2 and psdir=1 stable throughout.
  - ps_ack 16 cycles after the last falling edge, ps_err=0, ps_busy low the following cycle.
- steps=0 request: ps_busy 1 cycle after acceptance, ps_ack with ps_err=0, no pspulse edges.
- Drop pll_lock during the 2nd pulse of a 5-step request:
  - pspulse low, ready=0, ps_ack=1 and ps_err=1 in the same cycle.
  - relock_count=1, then a fresh RST_PLL sequence and ready restored.
- pll_lock held 0 (LOCK_TIMEOUT overridden to 100): timeout_err=1 after 100 WAIT_LOCK cycles, then repeated RST_PLL/WAIT_LOCK cycles.
- Lock glitch inside the filter (1 cycle low after 5 highs): filter restarts; ready only after 8 consecutive highs.
- Async rst mid-PS_HIGH: all outputs return to reset values without waiting for a clk edge.
- 300 induced lock losses: relock_count saturates at 255.
